// File: rtl/shift_pattern_decoder_pkg.sv
// Shared definitions for the shift-pattern decoder: FSM states, default
// geometry of the bouncing one-hot pattern and the phase-to-bit mapping.
package shift_pattern_decoder_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int DWELL_DEF    = 5;
  localparam int MAX_MISS_DEF = 3;
  localparam int PERIOD_DEF   = DWELL_DEF + 2 * WIDTH_DEF - 3;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Index of the bit the generator drives at phase p: dwell on bit0,
  // sweep up to bit(width-1), then back down to bit1.
  function automatic int unsigned expected_index(input int unsigned p,
                                                 input int unsigned width,
                                                 input int unsigned dwell);
    int unsigned idx;
    if (p < dwell) begin
      idx = 0;
    end else if (p < dwell + width - 1) begin
      idx = p - dwell + 1;
    end else begin
      idx = 2 * width + dwell - 3 - p;
    end
    return idx;
  endfunction

endpackage

// File: rtl/shift_pattern_decoder_if.sv
// Pattern bus between the generator and the decoder, carrying the sample
// stream one way and the recovered tracking status the other.
interface shift_pattern_decoder_if
  import shift_pattern_decoder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic                     in_valid;
  logic [WIDTH-1:0]         pattern;
  logic [4:0]               phase;
  logic [$clog2(WIDTH)-1:0] pos;
  logic                     dir;
  logic                     locked;
  logic                     err;
  logic [7:0]               err_count;
  logic                     period_done;

  modport master (
    output in_valid, pattern,
    input  phase, pos, dir, locked, err, err_count, period_done
  );

  modport slave (
    input  in_valid, pattern,
    output phase, pos, dir, locked, err, err_count, period_done
  );

endinterface

// File: rtl/shift_pattern_decoder_onehot_encoder.sv
// Combinational one-hot encoder: reports the index of the highest set bit
// and whether exactly one bit is set.
module shift_pattern_decoder_onehot_encoder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     is_onehot
);

  localparam int IDXW = $clog2(WIDTH);
  localparam int CNTW = $clog2(WIDTH + 1);

  logic [IDXW-1:0] idx_s;
  logic [CNTW-1:0] ones_s;

  // Population count and set-bit index in a single sweep.
  always_comb begin
    idx_s  = {IDXW{1'b0}};
    ones_s = {CNTW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      ones_s = ones_s + {{(CNTW-1){1'b0}}, vec[i]};
      idx_s  = vec[i] ? IDXW'(i) : idx_s;
    end
  end

  assign idx       = idx_s;
  assign is_onehot = (ones_s == {{(CNTW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/shift_pattern_decoder.sv
// Receive-side decoder for the bouncing one-hot pattern: acquires the
// generator phase from a bit0->bit1 edge, confirms it over one full period,
// then flywheels through isolated faults and counts pattern errors.
module shift_pattern_decoder
  import shift_pattern_decoder_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DWELL    = DWELL_DEF,
  parameter int MAX_MISS = MAX_MISS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_pattern_decoder_if.slave bus
);

  localparam int PERIOD = DWELL + 2 * WIDTH - 3;
  localparam int PHW    = 5;
  localparam int IDXW   = $clog2(WIDTH);
  localparam int MW     = $clog2(MAX_MISS + 1);
  localparam int CW     = $clog2(PERIOD + 1);
  localparam logic [WIDTH-1:0] BIT0 = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] BIT1 = {{(WIDTH-2){1'b0}}, 2'b10};

  state_t          state_r, state_n;
  logic [PHW-1:0]  phase_r, phase_n;
  logic [IDXW-1:0] pos_r, pos_n;
  logic            dir_r, dir_n;
  logic            locked_r, locked_n;
  logic            err_r, err_n;
  logic [7:0]      err_count_r, err_count_n;
  logic            period_done_r, period_done_n;
  logic [MW-1:0]   miss_r, miss_n;
  logic [CW-1:0]   match_r, match_n;
  logic            prev_zero_r, prev_zero_n;

  logic [IDXW-1:0]  idx_s;
  logic             is_onehot_s;
  logic [PHW-1:0]   phase_inc_s;
  logic [IDXW-1:0]  exp_idx_s;
  logic [WIDTH-1:0] exp_pat_s;
  logic             match_s;
  logic             err_hit_s;

  shift_pattern_decoder_onehot_encoder #(.WIDTH(WIDTH)) u_onehot (
    .vec       (bus.pattern),
    .idx       (idx_s),
    .is_onehot (is_onehot_s)
  );

  // The expected pattern is always the one for the phase after the current
  // one; a non-one-hot sample can never equal it, so it counts as a miss.
  assign phase_inc_s = (phase_r == PHW'(PERIOD - 1)) ? {PHW{1'b0}} : phase_r + PHW'(1);
  assign exp_idx_s   = IDXW'(expected_index(32'(phase_inc_s), WIDTH, DWELL));
  assign exp_pat_s   = BIT0 << exp_idx_s;
  assign match_s     = (bus.pattern == exp_pat_s);

  // Next-state and next-output logic for the search/acquire/locked tracker.
  always_comb begin
    state_n       = state_r;
    phase_n       = phase_r;
    pos_n         = pos_r;
    locked_n      = locked_r;
    err_n         = 1'b0;
    err_count_n   = err_count_r;
    period_done_n = 1'b0;
    miss_n        = miss_r;
    match_n       = match_r;
    prev_zero_n   = prev_zero_r;
    err_hit_s     = 1'b0;
    if (bus.in_valid) begin
      prev_zero_n = (bus.pattern == BIT0);
      if (is_onehot_s) begin
        pos_n = idx_s;
      end else begin
        pos_n = pos_r;
      end
      case (state_r)
        ST_SEARCH: begin
          if ((bus.pattern == BIT1) && prev_zero_r) begin
            state_n = ST_ACQUIRE;
            phase_n = PHW'(DWELL);
            match_n = CW'(1);
          end else begin
            state_n = ST_SEARCH;
          end
        end
        ST_ACQUIRE: begin
          if (match_s) begin
            phase_n = phase_inc_s;
            match_n = match_r + CW'(1);
            if (match_r == CW'(PERIOD - 1)) begin
              state_n  = ST_LOCKED;
              locked_n = 1'b1;
            end else begin
              state_n = ST_ACQUIRE;
            end
          end else begin
            err_hit_s = 1'b1;
            state_n   = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          phase_n       = phase_inc_s;
          period_done_n = (phase_inc_s == {PHW{1'b0}});
          if (match_s) begin
            miss_n = {MW{1'b0}};
          end else begin
            err_hit_s = 1'b1;
            if (miss_r == MW'(MAX_MISS - 1)) begin
              state_n  = ST_SEARCH;
              locked_n = 1'b0;
              miss_n   = {MW{1'b0}};
            end else begin
              miss_n = miss_r + MW'(1);
            end
          end
        end
        default: begin
          state_n  = ST_SEARCH;
          locked_n = 1'b0;
          miss_n   = {MW{1'b0}};
        end
      endcase
      if (err_hit_s) begin
        err_n       = 1'b1;
        err_count_n = (err_count_r == 8'hFF) ? err_count_r : err_count_r + 8'd1;
      end else begin
        err_count_n = err_count_r;
      end
    end else begin
      state_n = state_r;
    end
    dir_n = (phase_n >= PHW'(DWELL + WIDTH - 1));
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_SEARCH;
      phase_r       <= {PHW{1'b0}};
      pos_r         <= {IDXW{1'b0}};
      dir_r         <= 1'b0;
      locked_r      <= 1'b0;
      err_r         <= 1'b0;
      err_count_r   <= 8'd0;
      period_done_r <= 1'b0;
      miss_r        <= {MW{1'b0}};
      match_r       <= {CW{1'b0}};
      prev_zero_r   <= 1'b0;
    end else begin
      state_r       <= state_n;
      phase_r       <= phase_n;
      pos_r         <= pos_n;
      dir_r         <= dir_n;
      locked_r      <= locked_n;
      err_r         <= err_n;
      err_count_r   <= err_count_n;
      period_done_r <= period_done_n;
      miss_r        <= miss_n;
      match_r       <= match_n;
      prev_zero_r   <= prev_zero_n;
    end
  end

  assign bus.phase       = phase_r;
  assign bus.pos         = pos_r;
  assign bus.dir         = dir_r;
  assign bus.locked      = locked_r;
  assign bus.err         = err_r;
  assign bus.err_count   = err_count_r;
  assign bus.period_done = period_done_r;

endmodule

// File: tb/tb_shift_pattern_decoder.sv
// Scoreboard bench for shift_pattern_decoder: a sample-level reference model
// predicts every output after each clock; a negedge monitor compares.
module tb_shift_pattern_decoder;

  localparam int W        = 8;
  localparam int DW       = 5;
  localparam int MAXMISS  = 3;
  localparam int PER      = DW + 2 * W - 3;

  localparam int M_SEARCH  = 0;
  localparam int M_ACQUIRE = 1;
  localparam int M_LOCKED  = 2;

  typedef struct {
    logic [7:0] phase;
    logic [7:0] pos;
    logic [7:0] dir;
    logic [7:0] locked;
    logic [7:0] err;
    logic [7:0] err_count;
    logic [7:0] period_done;
  } exp_t;

  logic clk;
  logic reset;

  shift_pattern_decoder_if #(.WIDTH(W)) bus ();

  shift_pattern_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fails  = 0;
  exp_t sb_q[$];

  // Generator's full period, built from its walking-bit behaviour.
  logic [7:0] tbl[$];
  int gidx = 0;

  // Reference model state.
  int m_state, m_phase, m_pos, m_dir, m_locked, m_err, m_cnt, m_pd, m_miss, m_match;
  bit m_prev0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] p, input bit rst_n);
    int nxt;
    bit hit;
    m_err = 0;
    m_pd  = 0;
    if (!rst_n) begin
      m_state = M_SEARCH; m_phase = 0; m_pos = 0; m_dir = 0; m_locked = 0;
      m_cnt = 0; m_miss = 0; m_match = 0; m_prev0 = 0;
      return;
    end
    if (!v) return;
    if ($countones(p) == 1) m_pos = $clog2(p);
    nxt = (m_phase + 1) % PER;
    hit = (p == tbl[nxt]);
    case (m_state)
      M_SEARCH: begin
        if (p == 8'h02 && m_prev0) begin
          m_state = M_ACQUIRE; m_phase = DW; m_match = 1;
        end
      end
      M_ACQUIRE: begin
        if (hit) begin
          m_phase = nxt;
          m_match++;
          if (m_match == PER) begin m_state = M_LOCKED; m_locked = 1; end
        end else begin
          m_err = 1; m_state = M_SEARCH;
        end
      end
      M_LOCKED: begin
        m_phase = nxt;
        if (m_phase == 0) m_pd = 1;
        if (hit) m_miss = 0;
        else begin
          m_err = 1;
          m_miss++;
          if (m_miss == MAXMISS) begin m_state = M_SEARCH; m_locked = 0; m_miss = 0; end
        end
      end
      default: m_state = M_SEARCH;
    endcase
    if (m_err == 1 && m_cnt < 255) m_cnt++;
    m_prev0 = (p == 8'h01);
    m_dir = (m_phase >= DW + W - 1) ? 1 : 0;
  endtask

  // Apply one cycle of stimulus; expectation is queued once the edge occurs.
  task automatic drive(input bit v, input logic [7:0] p, input bit r);
    exp_t e;
    reset        = r;
    bus.in_valid = v;
    bus.pattern  = p;
    model_step(v, p, r);
    e.phase = 8'(m_phase); e.pos = 8'(m_pos); e.dir = 8'(m_dir);
    e.locked = 8'(m_locked); e.err = 8'(m_err); e.err_count = 8'(m_cnt);
    e.period_done = 8'(m_pd);
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, tbl[gidx], 1'b1);
      gidx = (gidx + 1) % PER;
    end
  endtask

  task automatic clean_until(input int target);
    int guard = 0;
    while (gidx != target && guard < 2 * PER) begin
      clean(1);
      guard++;
    end
    if (gidx != target) begin
      n_checks++;
      n_fails++;
      $display("FAIL clean_until: generator index %0d, wanted %0d", gidx, target);
    end
  endtask

  // Monitor: compare every registered output once per clock.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("phase",       8'(bus.phase),       e.phase);
      check("pos",         8'(bus.pos),         e.pos);
      check("dir",         8'(bus.dir),         e.dir);
      check("locked",      8'(bus.locked),      e.locked);
      check("err",         8'(bus.err),         e.err);
      check("err_count",   bus.err_count,       e.err_count);
      check("period_done", 8'(bus.period_done), e.period_done);
    end
  end

  initial begin
    int r;
    repeat (DW) tbl.push_back(8'h01);
    for (int b = 1; b < W; b++) tbl.push_back(8'h01 << b);
    for (int b = W - 2; b >= 1; b--) tbl.push_back(8'h01 << b);
    reset = 1'b0; bus.in_valid = 1'b0; bus.pattern = 8'h00;

    // 1: reset with random input, then acquire on bit0 x5, bit1.
    for (int i = 0; i < 3; i++) drive(1'($urandom), 8'($urandom), 1'b0);
    gidx = 0;
    clean(6);
    // 2: clean stream through lock and several wraps.
    clean(40);
    // 3: single corrupted up-sweep sample while locked.
    clean_until(11);
    drive(1'b1, 8'h40, 1'b1); gidx = (gidx + 1) % PER;
    clean(10);
    // 4: three dead samples drop lock, then reacquire.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h00, 1'b1); gidx = (gidx + 1) % PER;
    end
    clean(45);
    // 5: short first dwell after reset, then a two-hot sample mid-acquire.
    drive(1'b1, 8'h10, 1'b0);
    gidx = 2;
    clean_until(9);
    drive(1'b1, 8'h03, 1'b1); gidx = (gidx + 1) % PER;
    clean(50);
    // 6: valid gaps while locked, then reset in the down-sweep.
    for (int g = 0; g < 7; g++) begin
      clean($urandom_range(2, 6));
      r = $urandom_range(1, 3);
      for (int k = 0; k < r; k++) drive(1'b0, 8'($urandom), 1'b1);
    end
    clean_until(14);
    drive(1'b1, tbl[gidx], 1'b0);
    gidx = 0;
    clean(30);
    // Saturate err_count with repeated acquire-then-fault triplets.
    for (int i = 0; i < 270; i++) begin
      drive(1'b1, 8'h01, 1'b1);
      drive(1'b1, 8'h02, 1'b1);
      drive(1'b1, 8'h03, 1'b1);
    end
    // Randomized mix of clean samples, corruption, gaps and resets.
    drive(1'b1, 8'h00, 1'b0);
    gidx = $urandom_range(0, PER - 1);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) drive(1'b1, 8'($urandom), 1'b0);
      else if (r < 12) drive(1'b0, 8'($urandom), 1'b1);
      else if (r < 17) begin
        drive(1'b1, 8'($urandom), 1'b1); gidx = (gidx + 1) % PER;
      end else clean(1);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/shift_pattern_decoder.md
Name: shift_pattern_decoder

Overview:
Receive-side decoder for the bouncing one-hot LED pattern stream produced by the shift-counter generator.
- Checks each 8-bit sample against the expected dwell/up/down sequence.
- Recovers the generator phase, bit position and sweep direction.
- Acquires and holds lock, and counts pattern errors.
- Sits on the pattern bus between the generator and the display/self-test logic.

Parameters:
WIDTH, 8, pattern width; sweep runs bit0..bit(WIDTH-1)..bit1
DWELL, 5, consecutive bit0 samples per period (phases 0..DWELL-1)
MAX_MISS, 3, consecutive mismatches in LOCKED that force return to SEARCH
(derived constant) PERIOD = DWELL + 2*WIDTH - 3 = 18 by default

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
in_valid  input  1  pattern sample present this cycle
pattern  input  WIDTH  sample from generator
phase  output  5  phase of last accepted sample, 0..PERIOD-1
pos  output  3  index of set bit of last valid one-hot sample
dir  output  1  0 = dwell or up-sweep (phase < DWELL+WIDTH-1), 1 = down-sweep
locked  output  1  stream tracked for a full period without fault
err  output  1  one-cycle pulse on a mismatching or non-one-hot sample while not in SEARCH
err_count  output  8  saturating count of err pulses
period_done  output  1  one-cycle pulse when phase wraps PERIOD-1 -> 0 in LOCKED

Behaviour:
- Reset state (reset==0 at a clk edge): state=SEARCH; all outputs 0; internal miss_cnt, match_cnt and prev_zero cleared. Reset overrides every other event, including mid-acquisition or mid-lock.
- Only cycles with in_valid=1 update state. When in_valid=0, all registers hold and err/period_done are 0.
- All outputs are registered; latency is 1 clk from the sample.
- One-hot check: exactly one bit set.
  - pos updates only on one-hot samples.
  - A non-one-hot sample counts as a mismatch.
- Expected pattern for phase p:
  - p < DWELL: bit0
  - p < DWELL+WIDTH-1: bit(p-DWELL+1)
  - otherwise: bit(2*WIDTH+DWELL-3-p), i.e. phase 12 -> bit6, phase 17 -> bit1 by default
- SEARCH:
  - prev_zero = (last valid sample == bit0).
  - On sample == bit1 with prev_zero=1: go to ACQUIRE, phase=DWELL, match_cnt=1.
  - err is never raised in SEARCH.
- ACQUIRE:
  - Each sample is compared against expected(phase+1 mod PERIOD).
  - Match: phase advances and match_cnt increments. When match_cnt reaches PERIOD, go to LOCKED and set locked=1.
  - Mismatch: err pulse, err_count increments, go to SEARCH. phase holds its last value.
- LOCKED:
  - phase advances every valid sample, match or not (flywheel).
  - Match clears miss_cnt.
  - Mismatch: err pulse, err_count increments, miss_cnt increments. When miss_cnt reaches MAX_MISS, go to SEARCH and set locked=0 on the same edge.
  - period_done pulses on the wrap to 0.
- err_count saturates at 255 and never wraps.
- The generator's shorter first dwell after its own reset must not cause errors, because acquisition needs only one bit0 followed by bit1.

Decomposition:
- Shared package holds:
  - state encoding constants (SEARCH=0, ACQUIRE=1, LOCKED=2)
  - default WIDTH, DWELL and derived PERIOD
  - the phase-to-expected-pattern function, also used by the bench model and any generator rework
- One natural sub-module, onehot_encoder: WIDTH-bit input -> index plus is_onehot flag; purely combinational, instantiated once.

Test Plan:
1. Reset held low 3 cycles with a random pattern applied -> all outputs 0, state SEARCH. Release, then feed bit0 x5, bit1 -> phase=5, locked=0, err=0.
2. Clean generator stream of 40 samples -> locked rises 1 clk after the 18th matching sample following acquisition. phase sequence 5,6,...,17,0,... period_done pulses at each wrap, err_count=0.
3. In LOCKED, replace one bit7 sample (phase 11) with bit6 -> single err pulse, err_count=1, locked stays 1, phase continues to 12.
4. In LOCKED, inject 3 consecutive 8'h00 samples -> three err pulses, locked=0 after the third, state SEARCH; reacquires on the next bit0->bit1 edge.
5. During ACQUIRE, inject 8'b0000_0011 -> err pulse, return to SEARCH, pos unchanged from the previous sample.
6. Locked stream with in_valid deasserted for 7 random gaps -> outputs frozen during gaps, no err pulses, phase sequence unbroken. Drop reset mid-down-sweep -> all outputs 0 on the next edge.
